layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/nn_sched_pkg.sv | 20 ++
 rtl/index_counter.sv | 22 ++
 rtl/layer_scheduler.sv | 121 ++++++++++++
 tb/tb_layer_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_sched_pkg.sv
// Shared types and constants for the neural-layer scheduler.
// LAYER_SCHED_BIAS_EN adds the BIAS state to the encoding.
package nn_sched_pkg;
  localparam int ADDR_W    = 16;
  localparam int N_IN_DEF  = 16;
  localparam int N_OUT_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_ACT,
    S_WRITE,
    S_DONE
`ifdef LAYER_SCHED_BIAS_EN
    , S_BIAS
`endif
  } state_t;
endpackage

// File: rtl/index_counter.sv
// Saturating index counter with clear/enable and terminal-count flag.
// Holds at MAX-1 instead of wrapping; clear wins over enable.
module index_counter
  import nn_sched_pkg::*;
#(
  parameter int MAX = 16
) (
  input  logic              clk,
  input  logic              count_rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);
  assign tc = (cnt == ADDR_W'(MAX - 1));

  always_ff @(posedge clk or posedge count_rst) begin
    if (count_rst)      cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + ADDR_W'(1);
  end
endmodule

// File: rtl/layer_scheduler.sv
// Sequences CLEAR/MAC/DRAIN/ACT/WRITE per neuron; N_IN+4 cycles per neuron (N_IN+6 with bias).
// Optional LAYER_SCHED_BIAS_EN inserts a bias-weight read before activation; no backpressure.
module layer_scheduler
  import nn_sched_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic              clk,
  input  logic              count_rst,
  input  logic              start,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              act_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done
);
  state_t            state, ns;
  logic [ADDR_W-1:0] in_cnt, out_cnt;
  logic              in_tc, out_tc;
  logic              kill;

  assign kill = abort && (state != S_IDLE);

  index_counter #(.MAX(N_IN)) u_in_cnt (
    .clk       (clk),
    .count_rst (count_rst),
    .clr       (state == S_CLEAR),
    .en        (state == S_MAC),
    .cnt       (in_cnt),
    .tc        (in_tc)
  );

  index_counter #(.MAX(N_OUT)) u_out_cnt (
    .clk       (clk),
    .count_rst (count_rst),
    .clr       (state == S_IDLE),
    .en        (state == S_WRITE),
    .cnt       (out_cnt),
    .tc        (out_tc)
  );

  always_comb begin
    ns = state;
    if (kill) begin
      ns = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) ns = S_CLEAR;
        S_CLEAR: ns = S_MAC;
        S_MAC:   if (in_tc) ns = S_DRAIN;
`ifdef LAYER_SCHED_BIAS_EN
        S_DRAIN: ns = S_BIAS;
        S_BIAS:  ns = S_ACT;
        // act_en marks the second ACT cycle, after the bias product has landed
        S_ACT:   if (act_en) ns = S_WRITE;
`else
        S_DRAIN: ns = S_ACT;
        S_ACT:   ns = S_WRITE;
`endif
        S_WRITE: ns = out_tc ? S_DONE : S_CLEAR;
        S_DONE:  ns = S_IDLE;
        default: ns = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge count_rst) begin
    if (count_rst) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      rd_en   <= 1'b0;
      mac_en  <= 1'b0;
      acc_clr <= 1'b0;
      act_en  <= 1'b0;
      out_we  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= ns;
      ready   <= (ns == S_IDLE);
      busy    <= (ns != S_IDLE);
`ifdef LAYER_SCHED_BIAS_EN
      rd_en   <= (ns == S_MAC) || (ns == S_BIAS);
      act_en  <= (ns == S_ACT) && (state == S_ACT);
`else
      rd_en   <= (ns == S_MAC);
      act_en  <= (ns == S_ACT);
`endif
      mac_en  <= rd_en && !kill;
      acc_clr <= (ns == S_CLEAR);
      out_we  <= (ns == S_WRITE);
      done    <= (ns == S_DONE);
    end
  end

  // Addresses are decoded from the registered state and counter values.
  always_comb begin
    in_addr  = '0;
    w_addr   = '0;
    out_addr = '0;
    case (state)
      S_MAC: begin
        in_addr = in_cnt;
        w_addr  = out_cnt * ADDR_W'(N_IN) + in_cnt;
      end
`ifdef LAYER_SCHED_BIAS_EN
      S_BIAS:  w_addr = ADDR_W'(N_IN * N_OUT) + out_cnt;
`endif
      S_WRITE: out_addr = out_cnt;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: vector table for the first neuron plus
// multi-cycle sequences for abort, mid-run reset and held start.
module tb_layer_scheduler;
`ifdef LAYER_SCHED_BIAS_EN
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int PER = NI + 6;
`else
  localparam int NI = 16;
  localparam int NO = 8;
  localparam int PER = NI + 4;
`endif
  localparam int DONE_CYC = 1 + NO * PER;
  localparam int N3 = (NO > 3) ? 3 : NO - 1;
  localparam int NA = (NO > 2) ? 2 : NO - 1;

  typedef struct packed {
    logic        ready, busy, rd_en, mac_en, acc_clr, act_en, out_we, done;
    logic [15:0] in_addr, w_addr, out_addr;
  } out_t;

  typedef struct {
    logic start;
    logic abort;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        count_rst, start, abort;
  logic        ready, busy, rd_en, mac_en, acc_clr, act_en, out_we, done;
  logic [15:0] in_addr, w_addr, out_addr;

  int checks = 0;
  int errors = 0;
  int trace_bad, trail_bad, done_cnt, done_at, we_cnt, first_we_addr, first_we_cyc;
  int n3_first, n3_last;
  int bias_w [2];

  always #5 clk = ~clk;

  layer_scheduler #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .count_rst(count_rst), .start(start), .abort(abort),
    .ready(ready), .busy(busy), .rd_en(rd_en), .in_addr(in_addr),
    .w_addr(w_addr), .mac_en(mac_en), .acc_clr(acc_clr), .act_en(act_en),
    .out_we(out_we), .out_addr(out_addr), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o = '{ready, busy, rd_en, mac_en, acc_clr, act_en, out_we, done, in_addr, w_addr, out_addr};
    return o;
  endfunction

  function automatic vec_t mk(bit st, bit ab, bit rdy, bit bsy, bit rd, bit mac, bit clr,
                              bit act, bit we, bit dn, int ia, int wa, int oa);
    vec_t v;
    v.start = st;
    v.abort = ab;
    v.exp = '{rdy, bsy, rd, mac, clr, act, we, dn, 16'(ia), 16'(wa), 16'(oa)};
    return v;
  endfunction

  // Expected outputs in cycle c of a run (cycle 1 follows the start-sampling edge).
  function automatic out_t expect_at(int c);
    out_t e;
    int n, p;
    e = '0;
    if (c > DONE_CYC) begin
      e.ready = 1'b1;
      return e;
    end
    e.busy = 1'b1;
    if (c == DONE_CYC) begin
      e.done = 1'b1;
      return e;
    end
    n = (c - 1) / PER;
    p = (c - 1) % PER;
    if (p == 0) e.acc_clr = 1'b1;
    if (p >= 1 && p <= NI) begin
      e.rd_en   = 1'b1;
      e.in_addr = 16'(p - 1);
      e.w_addr  = 16'(n * NI + p - 1);
    end
    if (p >= 2 && p <= NI + 1) e.mac_en = 1'b1;
`ifdef LAYER_SCHED_BIAS_EN
    if (p == NI + 2) begin
      e.rd_en  = 1'b1;
      e.w_addr = 16'(NI * NO + n);
    end
    if (p == NI + 3) e.mac_en = 1'b1;
    if (p == NI + 4) e.act_en = 1'b1;
    if (p == NI + 5) begin
      e.out_we   = 1'b1;
      e.out_addr = 16'(n);
    end
`else
    if (p == NI + 2) e.act_en = 1'b1;
    if (p == NI + 3) begin
      e.out_we   = 1'b1;
      e.out_addr = 16'(n);
    end
`endif
    return e;
  endfunction

  task automatic clr_stats();
    trace_bad = 0; trail_bad = 0; done_cnt = 0; done_at = -1; we_cnt = 0;
    first_we_addr = -1; first_we_cyc = -1; n3_first = -1; n3_last = -1;
    bias_w[0] = -1; bias_w[1] = -1;
  endtask

  task automatic observe(input int c_from, input int c_to);
    out_t o;
    logic prev_rd;
    int n, p;
    prev_rd = rd_en;
    for (int c = c_from; c <= c_to; c++) begin
      tick();
      o = sample();
      if (o !== expect_at(c)) trace_bad++;
      if (o.mac_en !== prev_rd) trail_bad++;
      prev_rd = o.rd_en;
      if (o.done) begin done_cnt++; done_at = c; end
      if (o.out_we) begin
        we_cnt++;
        if (we_cnt == 1) begin first_we_addr = int'(o.out_addr); first_we_cyc = c; end
      end
      n = (c - 1) / PER;
      p = (c - 1) % PER;
      if (o.rd_en && n == N3 && p >= 1 && p <= NI) begin
        if (p == 1) n3_first = int'(o.w_addr);
        n3_last = int'(o.w_addr);
      end
      if (o.rd_en && p == NI + 2 && n < 2) bias_w[n] = int'(o.w_addr);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    count_rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;

    tbl.push_back(mk(1,0, 0,1,0,0,1,0,0,0, 0,0,0));
    for (int i = 0; i < NI; i++) tbl.push_back(mk(0,0, 0,1,1,(i > 0),0,0,0,0, i,i,0));
    tbl.push_back(mk(0,0, 0,1,0,1,0,0,0,0, 0,0,0));
`ifdef LAYER_SCHED_BIAS_EN
    tbl.push_back(mk(0,0, 0,1,1,0,0,0,0,0, 0,NI*NO,0));
    tbl.push_back(mk(0,0, 0,1,0,1,0,0,0,0, 0,0,0));
`endif
    tbl.push_back(mk(0,0, 0,1,0,0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0,0, 0,1,0,0,0,0,1,0, 0,0,0));
    tbl.push_back(mk(0,0, 0,1,0,0,1,0,0,0, 0,0,0));

    // Reset state
    #3;
    check("reset_outputs", sample(), out_t'({8'b1000_0000, 48'h0}));
    @(negedge clk) count_rst = 1'b0;
    tick();
    check("idle_after_release", sample(), out_t'({8'b1000_0000, 48'h0}));

    // First neuron cycle by cycle, then the rest of the layer
    foreach (tbl[k]) begin
      start = tbl[k].start;
      abort = tbl[k].abort;
      tick();
      check($sformatf("vec[%0d]", k), sample(), tbl[k].exp);
    end
    clr_stats();
    observe(tbl.size() + 1, DONE_CYC + 1);
    check("run_trace_bad", trace_bad, 0);
    check("run_mac_trail_bad", trail_bad, 0);
    check("run_done_cnt", done_cnt, 1);
    check("run_done_cycle", done_at, DONE_CYC);
    check("run_out_we_cnt", we_cnt, NO - 1);
    check("n3_first_w_addr", n3_first, N3 * NI);
    check("n3_last_w_addr", n3_last, N3 * NI + NI - 1);
`ifdef LAYER_SCHED_BIAS_EN
    check("bias_w_addr_n1", bias_w[1], NI * NO + 1);
`endif

    // Abort in MAC of neuron NA
    clr_stats();
    start_run();
    observe(2, NA * PER + 4);
    check("abort_pre_we_cnt", we_cnt, NA);
    check("abort_pre_rd_en", rd_en, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_mac_en", mac_en, 1'b0);
    we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      tick();
      if (out_we) we_cnt++;
      if (done) done_cnt++;
    end
    check("abort_no_out_we", we_cnt, 0);
    check("abort_no_done", done_cnt, 0);
    clr_stats();
    start_run();
    observe(2, DONE_CYC + 1);
    check("restart_trace_bad", trace_bad, 0);
    check("restart_done_cycle", done_at, DONE_CYC);
    check("restart_done_cnt", done_cnt, 1);
`ifdef LAYER_SCHED_BIAS_EN
    check("bias_w_addr_n0", bias_w[0], NI * NO);
`endif

    // Asynchronous reset in the WRITE cycle of neuron NA
    clr_stats();
    start_run();
    observe(2, NA * PER + PER);
    check("pre_rst_out_we", out_we, 1'b1);
    check("pre_rst_out_addr", out_addr, 16'(NA));
    #2 count_rst = 1'b1;
    #1;
    check("rst_async_outputs", sample(), out_t'({8'b1000_0000, 48'h0}));
    @(negedge clk) count_rst = 1'b0;
    tick();
    clr_stats();
    start_run();
    observe(2, DONE_CYC + 1);
    check("rst_restart_first_addr", first_we_addr, 0);
    check("rst_restart_first_we_cyc", first_we_cyc, PER);
    check("rst_restart_done_cycle", done_at, DONE_CYC);

    // start held high through a whole layer
    clr_stats();
    start = 1'b1;
    tick();
    observe(2, DONE_CYC + 1);
    check("held_trace_bad", trace_bad, 0);
    check("held_done_cnt", done_cnt, 1);
    tick();
    check("held_rerun_acc_clr", acc_clr, 1'b1);
    check("held_rerun_busy", busy, 1'b1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("held_abort_ready", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
